// File: rtl/nn_score_discriminator_pkg.sv
// Shared definitions for the NN post-processing stages: score format and
// the discriminator control FSM encoding.
package nn_post_pkg;

  localparam int SCORE_W = 18;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

endpackage

// File: rtl/nn_score_discriminator_if.sv
// Score stream in, per-shot decision out, and the batch-summary handshake
// between the discriminator and the readout/host side.
interface nn_score_if #(
  parameter int SCORE_W = nn_post_pkg::SCORE_W,
  parameter int CNT_W   = 11,
  parameter int SUM_W   = 28
);
  logic signed [SCORE_W-1:0] score_in;
  logic                      score_vld;
  logic                      state_out;
  logic                      state_vld;
  logic        [CNT_W-1:0]   batch_ones;
  logic signed [SUM_W-1:0]   batch_sum;
  logic                      batch_vld;
  logic                      batch_rdy;

  modport master (
    output score_in, score_vld, batch_rdy,
    input  state_out, state_vld, batch_ones, batch_sum, batch_vld
  );

  modport slave (
    input  score_in, score_vld, batch_rdy,
    output state_out, state_vld, batch_ones, batch_sum, batch_vld
  );
endinterface

// File: rtl/nn_score_discriminator_fifo.sv
// First-word fall-through FIFO; the head is visible whenever not empty and a
// push into a full FIFO is accepted when a pop happens on the same edge.
module nn_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Reads as zero when empty so the downstream head fields idle at 0.
  assign dout    = empty ? '0 : mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/nn_score_discriminator.sv
// Thresholds NN scores into per-shot state bits and collects per-batch
// ones-count / score-sum summaries into a FWFT FIFO for the host.
module nn_score_discriminator #(
  parameter int SCORE_W    = nn_post_pkg::SCORE_W,
  parameter int BATCH      = 1024,
  parameter int CNT_W      = $clog2(BATCH+1),
  parameter int SUM_W      = SCORE_W + $clog2(BATCH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      start,
  input  logic [15:0]               n_batches,
  input  logic                      abort,
  input  logic signed [SCORE_W-1:0] thresh_in,
  input  logic                      thresh_load,
  nn_score_if.slave                 bus,
  output logic                      busy,
  output logic                      overflow
);
  import nn_post_pkg::*;

  localparam logic [CNT_W-1:0] LAST_SHOT = CNT_W'(BATCH - 1);

  fsm_e                      state_q, state_d;
  logic signed [SCORE_W-1:0] thr_q;
  logic        [CNT_W-1:0]   shot_cnt_q, ones_q, ones_nxt;
  logic signed [SUM_W-1:0]   sum_q, sum_nxt;
  logic        [15:0]        batch_cnt_q, nb_q;
  logic                      accept, decision, last_shot, run_done;
  logic                      fifo_full, fifo_empty, pop;

  // abort wins over a coincident score; that shot is part of the dropped batch.
  assign accept    = (state_q == RUN) && bus.score_vld && !abort;
  assign decision  = ($signed(bus.score_in) >= $signed(thr_q));
  assign last_shot = accept && (shot_cnt_q == LAST_SHOT);
  assign run_done  = last_shot && (nb_q != 16'd0) && ((batch_cnt_q + 16'd1) == nb_q);
  assign ones_nxt  = ones_q + CNT_W'(decision);
  assign sum_nxt   = sum_q + SUM_W'($signed(bus.score_in));
  assign pop       = bus.batch_vld && bus.batch_rdy;
  assign busy      = (state_q == RUN);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (abort || run_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      thr_q         <= '0;
      bus.state_out <= 1'b0;
      bus.state_vld <= 1'b0;
      shot_cnt_q    <= '0;
      ones_q        <= '0;
      sum_q         <= '0;
      batch_cnt_q   <= '0;
      nb_q          <= '0;
      overflow      <= 1'b0;
    end else begin
      if (thresh_load) thr_q <= thresh_in;
      bus.state_vld <= accept;
      bus.state_out <= accept && decision;

      if (state_q == IDLE && start) begin
        shot_cnt_q  <= '0;
        ones_q      <= '0;
        sum_q       <= '0;
        batch_cnt_q <= '0;
        nb_q        <= n_batches;
        overflow    <= 1'b0;
      end else if (state_q == RUN && abort) begin
        shot_cnt_q <= '0;
        ones_q     <= '0;
        sum_q      <= '0;
      end else if (last_shot) begin
        shot_cnt_q  <= '0;
        ones_q      <= '0;
        sum_q       <= '0;
        batch_cnt_q <= batch_cnt_q + 16'd1;
        // A pop on the same edge frees the slot, so a full FIFO only drops without one.
        if (fifo_full && !pop) overflow <= 1'b1;
      end else if (accept) begin
        shot_cnt_q <= shot_cnt_q + CNT_W'(1);
        ones_q     <= ones_nxt;
        sum_q      <= sum_nxt;
      end
    end
  end

  assign bus.batch_vld = !fifo_empty;

  nn_sync_fifo #(
    .WIDTH (CNT_W + SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (last_shot),
    .din   ({ones_nxt, sum_nxt}),
    .pop   (pop),
    .dout  ({bus.batch_ones, bus.batch_sum}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_nn_score_discriminator.sv
// Bench for nn_score_discriminator with BATCH=4, FIFO_DEPTH=4: directed
// scenarios plus a randomized run against a transaction-level model.
module tb_nn_score_discriminator;
  import nn_post_pkg::*;

  localparam int BATCH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int SUM_W = 20;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic               start, abort, thresh_load;
  logic [15:0]        n_batches;
  score_t             thresh_in;
  logic               busy, overflow;

  nn_score_if #(.SCORE_W(SCORE_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bif ();

  nn_score_discriminator #(
    .SCORE_W(SCORE_W), .BATCH(BATCH), .CNT_W(CNT_W), .SUM_W(SUM_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .n_batches(n_batches),
    .abort(abort), .thresh_in(thresh_in), .thresh_load(thresh_load),
    .bus(bif), .busy(busy), .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: run flag, partial batch, and summary queue.
  int  m_thr, m_cnt, m_ones, m_sum, m_batches, m_nb;
  bit  m_run, m_ovf, e_svld, e_sout;
  int  q_ones[$];
  int  q_sum[$];

  task automatic model_reset();
    m_thr = 0; m_cnt = 0; m_ones = 0; m_sum = 0; m_batches = 0; m_nb = 0;
    m_run = 0; m_ovf = 0; e_svld = 0; e_sout = 0;
    q_ones.delete(); q_sum.delete();
  endtask

  task automatic model_edge();
    bit was_run, do_pop, acc, d;
    int s;
    was_run = m_run;
    s       = bif.score_in;
    do_pop  = (q_ones.size() > 0) && bif.batch_rdy;
    acc     = was_run && bif.score_vld && !abort;
    d       = (s >= m_thr);
    e_svld  = acc;
    e_sout  = acc && d;
    if (do_pop) begin
      void'(q_ones.pop_front());
      void'(q_sum.pop_front());
    end
    if (acc) begin
      m_cnt++; m_ones += int'(d); m_sum += s;
      if (m_cnt == BATCH) begin
        if (q_ones.size() < DEPTH) begin
          q_ones.push_back(m_ones);
          q_sum.push_back(m_sum);
        end else m_ovf = 1;
        m_cnt = 0; m_ones = 0; m_sum = 0;
        m_batches++;
        if (m_nb != 0 && m_batches == m_nb) m_run = 0;
      end
    end
    if (was_run && abort) begin
      m_run = 0; m_cnt = 0; m_ones = 0; m_sum = 0;
    end
    if (!was_run && start) begin
      m_run = 1; m_cnt = 0; m_ones = 0; m_sum = 0;
      m_batches = 0; m_ovf = 0; m_nb = int'(n_batches);
    end
    if (thresh_load) m_thr = thresh_in;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic pulse_start(input int nb);
    n_batches = 16'(nb);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    start = 0; abort = 0; thresh_load = 0; thresh_in = '0; n_batches = '0;
    bif.score_in = '0; bif.score_vld = 0; bif.batch_rdy = 0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (bif.state_out !== 1'b0) begin errors++; $display("FAIL reset_state_out: got %b want 0", bif.state_out); end
    if (bif.state_vld !== 1'b0) begin errors++; $display("FAIL reset_state_vld: got %b want 0", bif.state_vld); end
    if (bif.batch_vld !== 1'b0) begin errors++; $display("FAIL reset_batch_vld: got %b want 0", bif.batch_vld); end
    if (bif.batch_ones !== '0) begin errors++; $display("FAIL reset_batch_ones: got %0d want 0", bif.batch_ones); end
    if (bif.batch_sum !== '0) begin errors++; $display("FAIL reset_batch_sum: got %0d want 0", bif.batch_sum); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_idle_ignore();
    bif.score_in = 18'sd5; bif.score_vld = 1'b1;
    repeat (4) begin
      cycle();
      checks += 3;
      if (bif.state_vld !== 1'b0) begin errors++; $display("FAIL idle_state_vld: got %b want 0", bif.state_vld); end
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
      if (bif.batch_vld !== 1'b0) begin errors++; $display("FAIL idle_batch_vld: got %b want 0", bif.batch_vld); end
    end
    bif.score_vld = 1'b0;
  endtask

  task automatic test_basic_batch();
    int sc[4] = '{-3, 0, 7, -1};
    bit ex[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    pulse_start(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      bif.score_in = 18'(sc[i]); bif.score_vld = 1'b1;
      cycle();
      checks += 3;
      if (bif.state_vld !== 1'b1) begin errors++; $display("FAIL basic_state_vld[%0d]: got %b want 1", i, bif.state_vld); end
      if (bif.state_out !== ex[i]) begin errors++; $display("FAIL basic_state_out[%0d]: got %b want %b", i, bif.state_out, ex[i]); end
      if (bif.batch_vld !== (i == 3)) begin errors++; $display("FAIL basic_batch_vld[%0d]: got %b want %b", i, bif.batch_vld, (i == 3)); end
    end
    bif.score_vld = 1'b0;
    checks += 3;
    if (bif.batch_ones !== 3'd2) begin errors++; $display("FAIL basic_ones: got %0d want 2", bif.batch_ones); end
    if ($signed(bif.batch_sum) !== 20'sd3) begin errors++; $display("FAIL basic_sum: got %0d want 3", $signed(bif.batch_sum)); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    cycle();
    checks += 2;
    if (bif.state_vld !== 1'b0) begin errors++; $display("FAIL basic_state_vld_pulse: got %b want 0", bif.state_vld); end
    if (bif.batch_vld !== 1'b1) begin errors++; $display("FAIL basic_batch_hold: got %b want 1", bif.batch_vld); end
    bif.batch_rdy = 1'b1;
    cycle();
    bif.batch_rdy = 1'b0;
    checks++;
    if (bif.batch_vld !== 1'b0) begin errors++; $display("FAIL basic_pop_empty: got %b want 0", bif.batch_vld); end
  endtask

  task automatic test_two_batches();
    int eo[2] = '{0, 0};
    int es[2] = '{0, 0};
    int s;
    pulse_start(2);
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(2000) - 1000;
      eo[i/4] += int'(s >= 0);
      es[i/4] += s;
      bif.score_in = 18'(s); bif.score_vld = 1'b1;
      cycle();
    end
    bif.score_vld = 1'b0;
    cycle();
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL two_busy: got %b want 0", busy); end
    if (bif.batch_vld !== 1'b1) begin errors++; $display("FAIL two_vld0: got %b want 1", bif.batch_vld); end
    if (bif.batch_ones !== 3'(eo[0])) begin errors++; $display("FAIL two_ones0: got %0d want %0d", bif.batch_ones, eo[0]); end
    if ($signed(bif.batch_sum) !== 20'(es[0])) begin errors++; $display("FAIL two_sum0: got %0d want %0d", $signed(bif.batch_sum), es[0]); end
    bif.batch_rdy = 1'b1;
    cycle();
    checks += 3;
    if (bif.batch_vld !== 1'b1) begin errors++; $display("FAIL two_vld1: got %b want 1", bif.batch_vld); end
    if (bif.batch_ones !== 3'(eo[1])) begin errors++; $display("FAIL two_ones1: got %0d want %0d", bif.batch_ones, eo[1]); end
    if ($signed(bif.batch_sum) !== 20'(es[1])) begin errors++; $display("FAIL two_sum1: got %0d want %0d", $signed(bif.batch_sum), es[1]); end
    cycle();
    bif.batch_rdy = 1'b0;
    checks++;
    if (bif.batch_vld !== 1'b0) begin errors++; $display("FAIL two_empty: got %b want 0", bif.batch_vld); end
  endtask

  task automatic test_overflow();
    int drained = 0;
    pulse_start(0);
    for (int i = 0; i < 5 * BATCH; i++) begin
      bif.score_in = 18'($urandom_range(4000) - 2000); bif.score_vld = 1'b1;
      cycle();
    end
    bif.score_vld = 1'b0;
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    if (bif.batch_vld !== 1'b1) begin errors++; $display("FAIL ovf_vld: got %b want 1", bif.batch_vld); end
    do_abort();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL ovf_abort_busy: got %b want 0", busy); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    pulse_start(0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_start_clear: got %b want 0", overflow); end
    // Close a batch into the full FIFO while popping on the same edge.
    for (int i = 0; i < BATCH; i++) begin
      bif.score_in = 18'($urandom_range(4000) - 2000); bif.score_vld = 1'b1;
      bif.batch_rdy = (i == BATCH - 1);
      cycle();
    end
    bif.score_vld = 1'b0; bif.batch_rdy = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_push_pop_full: got %b want 0", overflow); end
    do_abort();
    bif.batch_rdy = 1'b1;
    for (int k = 0; k < 10 && bif.batch_vld === 1'b1; k++) begin
      checks += 2;
      if (bif.batch_ones !== 3'(q_ones[0])) begin errors++; $display("FAIL ovf_drain_ones: got %0d want %0d", bif.batch_ones, q_ones[0]); end
      if ($signed(bif.batch_sum) !== 20'(q_sum[0])) begin errors++; $display("FAIL ovf_drain_sum: got %0d want %0d", $signed(bif.batch_sum), q_sum[0]); end
      cycle();
      drained++;
    end
    bif.batch_rdy = 1'b0;
    checks++;
    if (drained != DEPTH) begin errors++; $display("FAIL ovf_drain_count: got %0d want %0d", drained, DEPTH); end
  endtask

  task automatic test_threshold();
    int sc[3] = '{8, 8, 10};
    bit ex[3] = '{1'b1, 1'b0, 1'b1};
    pulse_start(0);
    for (int i = 0; i < 3; i++) begin
      thresh_in = 18'sd10; thresh_load = (i == 0);
      bif.score_in = 18'(sc[i]); bif.score_vld = 1'b1;
      cycle();
      checks++;
      if (bif.state_out !== ex[i]) begin errors++; $display("FAIL thr_state[%0d]: got %b want %b", i, bif.state_out, ex[i]); end
    end
    thresh_load = 1'b0; bif.score_vld = 1'b0;
    do_abort();
    thresh_in = -18'sd5; thresh_load = 1'b1;
    cycle();
    thresh_load = 1'b0;
    pulse_start(0);
    bif.score_in = -18'sd5; bif.score_vld = 1'b1;
    cycle();
    checks++;
    if (bif.state_out !== 1'b1) begin errors++; $display("FAIL thr_neg_eq: got %b want 1", bif.state_out); end
    bif.score_in = -18'sd6;
    cycle();
    checks++;
    if (bif.state_out !== 1'b0) begin errors++; $display("FAIL thr_neg_below: got %b want 0", bif.state_out); end
    bif.score_vld = 1'b0;
    do_abort();
    thresh_in = '0; thresh_load = 1'b1;
    cycle();
    thresh_load = 1'b0;
  endtask

  task automatic test_abort();
    int sc[4] = '{5, -9, 2, -1};
    pulse_start(0);
    for (int i = 0; i < 2; i++) begin
      bif.score_in = 18'sd100; bif.score_vld = 1'b1;
      cycle();
    end
    bif.score_vld = 1'b0;
    do_abort();
    cycle();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (bif.batch_vld !== 1'b0) begin errors++; $display("FAIL abort_no_summary: got %b want 0", bif.batch_vld); end
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      bif.score_in = 18'(sc[i]); bif.score_vld = 1'b1;
      cycle();
    end
    bif.score_vld = 1'b0;
    checks += 3;
    if (bif.batch_vld !== 1'b1) begin errors++; $display("FAIL restart_vld: got %b want 1", bif.batch_vld); end
    if (bif.batch_ones !== 3'd2) begin errors++; $display("FAIL restart_ones: got %0d want 2", bif.batch_ones); end
    if ($signed(bif.batch_sum) !== -20'sd3) begin errors++; $display("FAIL restart_sum: got %0d want -3", $signed(bif.batch_sum)); end
    bif.batch_rdy = 1'b1;
    cycle();
    bif.batch_rdy = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      start       = ($urandom_range(19) == 0);
      n_batches   = 16'($urandom_range(3));
      abort       = ($urandom_range(59) == 0);
      thresh_load = ($urandom_range(19) == 0);
      thresh_in   = 18'($urandom);
      bif.score_in  = 18'($urandom);
      bif.score_vld = ($urandom_range(9) < 7);
      bif.batch_rdy = ($urandom_range(3) == 0);
      cycle();
      checks += 5;
      if (bif.state_vld !== e_svld) begin errors++; $display("FAIL rnd_state_vld@%0d: got %b want %b", c, bif.state_vld, e_svld); end
      if (bif.state_out !== e_sout) begin errors++; $display("FAIL rnd_state_out@%0d: got %b want %b", c, bif.state_out, e_sout); end
      if (busy !== m_run) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, m_run); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow@%0d: got %b want %b", c, overflow, m_ovf); end
      if (bif.batch_vld !== (q_ones.size() > 0)) begin errors++; $display("FAIL rnd_batch_vld@%0d: got %b want %b", c, bif.batch_vld, q_ones.size() > 0); end
      if (q_ones.size() > 0) begin
        checks += 2;
        if (bif.batch_ones !== 3'(q_ones[0])) begin errors++; $display("FAIL rnd_ones@%0d: got %0d want %0d", c, bif.batch_ones, q_ones[0]); end
        if ($signed(bif.batch_sum) !== 20'(q_sum[0])) begin errors++; $display("FAIL rnd_sum@%0d: got %0d want %0d", c, $signed(bif.batch_sum), q_sum[0]); end
      end
    end
    start = 0; abort = 0; thresh_load = 0; bif.score_vld = 0; bif.batch_rdy = 0;
  endtask

  task automatic test_async_reset();
    if (m_run) do_abort();
    pulse_start(0);
    for (int i = 0; i < 2; i++) begin
      bif.score_in = 18'sd1; bif.score_vld = 1'b1;
      cycle();
    end
    bif.score_vld = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    checks += 7;
    if (bif.state_vld !== 1'b0) begin errors++; $display("FAIL arst_state_vld: got %b want 0", bif.state_vld); end
    if (bif.state_out !== 1'b0) begin errors++; $display("FAIL arst_state_out: got %b want 0", bif.state_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    if (bif.batch_vld !== 1'b0) begin errors++; $display("FAIL arst_batch_vld: got %b want 0", bif.batch_vld); end
    if (bif.batch_ones !== '0) begin errors++; $display("FAIL arst_batch_ones: got %0d want 0", bif.batch_ones); end
    if (bif.batch_sum !== '0) begin errors++; $display("FAIL arst_batch_sum: got %0d want 0", bif.batch_sum); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow: got %b want 0", overflow); end
    model_reset();
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (3) cycle();
    checks++;
    if (bif.batch_vld !== 1'b0) begin errors++; $display("FAIL arst_no_partial: got %b want 0", bif.batch_vld); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic_batch();
    test_two_batches();
    test_overflow();
    test_threshold();
    test_abort();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nn_score_discriminator.md
# nn_score_discriminator

Downstream post-processing stage for the readout network. It consumes the 18-bit signed score produced each shot by the normalize/NN stage (`output_2_V`) and thresholds it into a per-shot state bit. It accumulates per-batch statistics (ones count, score sum) and hands completed batch summaries to the readout/host side through a small FIFO with a valid/ready handshake.

## Interface
Parameters:
- SCORE_W, 18, score width (signed two's complement, same format as NN output)
- BATCH, 1024, shots per batch summary (≥1)
- CNT_W, $clog2(BATCH+1), ones-count width
- SUM_W, SCORE_W+$clog2(BATCH), score-sum width (signed)
- FIFO_DEPTH, 4, batch-summary FIFO entries (power of 2, ≥2)

Ports:
- ap_clk  in  1  sole clock, rising edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse, arms acquisition
- n_batches  in  16  batches per run, sampled on start; 0 = continuous
- abort  in  1  synchronous pulse, return to IDLE, drop partial batch
- thresh_in  in  SCORE_W  new threshold (signed)
- thresh_load  in  1  loads thresh_in into threshold register
- score_in  in  SCORE_W  NN score
- score_vld  in  1  score_in valid this cycle
- state_out  out  1  per-shot decision, 1 when score ≥ threshold
- state_vld  out  1  state_out valid (one-cycle pulse)
- batch_ones  out  CNT_W  FIFO head: shots decided 1
- batch_sum  out  SUM_W  FIFO head: signed score sum
- batch_vld  out  1  FIFO head valid
- batch_rdy  in  1  consumer accepts head when batch_vld & batch_rdy
- busy  out  1  FSM not IDLE
- overflow  out  1  sticky: a batch summary was dropped

## Operation
- FSM states: IDLE, RUN. IDLE→RUN on start. RUN→IDLE when the completed-batch count equals the latched n_batches (n_batches≠0), or on abort. start while in RUN is ignored.
- In IDLE, score_vld is ignored: no state_vld, no accumulation.
- In RUN, each score_vld: decision = (score_in ≥ threshold), signed compare; equality gives 1. shot_cnt++, ones += decision, sum += sign-extended score_in.
- Batch close: the shot making shot_cnt reach BATCH writes {ones, sum} including that shot into the FIFO on the same edge; shot_cnt/ones/sum clear to 0 on that edge; batch counter increments.
- FIFO full at batch close: summary dropped, overflow set, accumulators still clear, batch still counted. overflow clears only on reset or start.
- Threshold register resets to 0. thresh_load is honoured in any state. With thresh_load and score_vld in the same cycle, the compare uses the old threshold.
- abort or run-complete: partial-batch accumulators clear. FIFO contents are retained and remain drainable.
- start clears the accumulators, the batch counter and overflow. It does not flush the FIFO.
- SUM_W is sized so the sum cannot overflow for BATCH shots. No saturation logic is required.

## Timing
- Reset values: state_out 0, state_vld 0, batch_vld 0, batch_ones 0, batch_sum 0, busy 0, overflow 0. FIFO empty, FSM IDLE, threshold 0.
- Per-shot latency: score_vld sampled at edge E → state_out/state_vld valid in the cycle after E (registered), for exactly one cycle.
- Batch latency: summary written at edge E of the final shot. The FIFO is first-word fall-through, so batch_vld is high the cycle after E when the FIFO was empty.
- Back-to-back score_vld every cycle is supported with no bubbles.
- Handshake: the head pops on the edge where batch_vld & batch_rdy. batch_ones/batch_sum are stable while batch_vld & !batch_rdy.
- A simultaneous pop and push on a full FIFO succeeds, with no drop and no overflow.
- busy falls the cycle after the edge that completes the final batch or samples abort.
- Asynchronous reset mid-run: all state returns to reset values immediately, and no partial summary is emitted.

## Structure
- Package nn_post_pkg: SCORE_W, score typedef (signed logic [SCORE_W-1:0]), and the FSM state enum. It is shared with the normalize stage's output width.
- One sub-module: nn_sync_fifo, a parameterised width/depth first-word fall-through FIFO with full/empty and simultaneous push/pop. It is instantiated once for the {ones, sum} summaries.
- The FSM, comparator, accumulators and threshold register live in the top module.

## Test plan
- Reset, then score_vld with score 5 and threshold 0, while in IDLE → no state_vld, no accumulation, busy 0.
- BATCH=4, thresh 0, start, scores -3, 0, 7, -1 on consecutive cycles → state_out 0,1,1,0, each one cycle after input. One summary: ones=2, sum=3. batch_vld rises the cycle after the 4th score.
- n_batches=2, BATCH=4, batch_rdy=0, 8 scores → two FIFO entries and busy falls. Then batch_rdy=1 → two pops in order, then batch_vld 0.
- FIFO_DEPTH=4, batch_rdy=0, 5 complete batches → 4 entries kept, overflow=1. A start pulse clears overflow.
- thresh_load with thresh_in=10 and score 8 in the same cycle (old threshold 0) → state 1. A following score 8 → state 0. A score of exactly 10 → state 1.
- Two scores into a BATCH=4 run, then abort → no summary, busy 0. Restart with 4 scores → summary reflects only the new 4 shots. Async reset asserted mid-batch → all outputs 0 immediately.
